// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcodes, instruction formats, field positions,
// immediate limits and the encoder state encoding.
package cpu_isa_pkg;

  typedef enum logic [3:0] {
    OP_JAL  = 4'b0000,
    OP_JALR = 4'b0001,
    OP_BEQ  = 4'b0010,
    OP_BLE  = 4'b0011,
    OP_LB   = 4'b0100,
    OP_LW   = 4'b0101,
    OP_SB   = 4'b0110,
    OP_SW   = 4'b0111,
    OP_ADD  = 4'b1000,
    OP_SUB  = 4'b1001,
    OP_AND  = 4'b1010,
    OP_OR   = 4'b1011,
    OP_ADDI = 4'b1100,
    OP_SUBI = 4'b1101,
    OP_LUI  = 4'b1110,
    OP_ILL  = 4'b1111
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_U,
    FMT_X
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR_LO = 2'd1,
    ST_WR_HI = 2'd2
  } enc_state_e;

  // Field positions within the 16-bit word: A = [11:9], B = [8:6], C = [5:3].
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int FA_MSB = 11;
  localparam int FA_LSB = 9;
  localparam int FB_MSB = 8;
  localparam int FB_LSB = 6;
  localparam int FC_MSB = 5;
  localparam int FC_LSB = 3;
  localparam int IMM6_MSB = 5;
  localparam int IMM9_MSB = 8;
  localparam int IMM8_MSB = 7;

  localparam int IMM6_MIN = -32;
  localparam int IMM6_MAX = 31;
  localparam int IMM9_MIN = -256;
  localparam int IMM9_MAX = 255;
  localparam int LUI_MAX  = 255;

  function automatic fmt_e op_format(input opcode_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR:             return FMT_R;
      OP_ADDI, OP_SUBI, OP_LB, OP_LW, OP_JALR:   return FMT_I;
      OP_SB, OP_SW:                              return FMT_S;
      OP_BEQ, OP_BLE:                            return FMT_B;
      OP_JAL:                                    return FMT_J;
      OP_LUI:                                    return FMT_U;
      default:                                   return FMT_X;
    endcase
  endfunction

  // Signed range test of a two's-complement 16-bit immediate.
  function automatic logic imm_fits(input logic [15:0] imm, input int lo, input int hi);
    int v;
    v = int'($signed(imm));
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: builds the 16-bit instruction word from its fields
// and flags illegal opcodes or out-of-range immediates.
module instr_field_pack
  import cpu_isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [2:0]  rd,
  input  logic [2:0]  rs1,
  input  logic [2:0]  rs2,
  input  logic [15:0] imm,
  output logic [15:0] word,
  output logic        legal
);

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    word               = '0;
    legal              = 1'b0;
    word[OP_MSB:OP_LSB] = op;
    case (op_format(opcode_e'(op)))
      FMT_R: begin
        word[FA_MSB:FA_LSB] = rd;
        word[FB_MSB:FB_LSB] = rs1;
        word[FC_MSB:FC_LSB] = rs2;
        legal               = 1'b1;
      end
      FMT_I: begin
        word[FA_MSB:FA_LSB] = rd;
        word[FB_MSB:FB_LSB] = rs1;
        word[IMM6_MSB:0]    = imm[IMM6_MSB:0];
        legal               = imm_fits(imm, IMM6_MIN, IMM6_MAX);
      end
      FMT_S: begin
        word[FA_MSB:FA_LSB] = rs2;
        word[FB_MSB:FB_LSB] = rs1;
        word[IMM6_MSB:0]    = imm[IMM6_MSB:0];
        legal               = imm_fits(imm, IMM6_MIN, IMM6_MAX);
      end
      FMT_B: begin
        word[FA_MSB:FA_LSB] = rs1;
        word[FB_MSB:FB_LSB] = rs2;
        word[IMM6_MSB:0]    = imm[IMM6_MSB:0];
        legal               = imm_fits(imm, IMM6_MIN, IMM6_MAX);
      end
      FMT_J: begin
        word[FA_MSB:FA_LSB] = rd;
        word[IMM9_MSB:0]    = imm[IMM9_MSB:0];
        legal               = imm_fits(imm, IMM9_MIN, IMM9_MAX);
      end
      FMT_U: begin
        // lui immediate is unsigned: anything with upper bits set is out of range.
        word[FA_MSB:FA_LSB] = rd;
        word[IMM8_MSB:0]    = imm[IMM8_MSB:0];
        legal               = (int'(imm) <= LUI_MAX);
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts instruction fields, packs them and writes the
// 16-bit word little-endian into byte-wide instruction memory over two cycles.
module instr_encoder
  import cpu_isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        base_load,
  input  logic [15:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [2:0]  rd,
  input  logic [2:0]  rs1,
  input  logic [2:0]  rs2,
  input  logic [15:0] imm,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [15:0] instr_cnt,
  output logic        err,
  output logic [3:0]  err_op,
  input  logic        err_clr,
  output logic        wrap
);

  enc_state_e  r_state;
  enc_state_e  w_next_state;
  logic [15:0] r_word;
  logic        r_legal;
  logic [15:0] r_wr_ptr;
  logic [15:0] r_instr_cnt;
  logic        r_err;
  logic [3:0]  r_err_op;
  logic        r_wrap;

  logic [15:0] w_word;
  logic        w_legal;
  logic        w_accept;
  logic        w_idle;
  logic        w_wr_done;
  logic [15:0] w_ptr_next;
  logic        w_ptr_carry;

  instr_field_pack u_pack (
    .op    (op),
    .rd    (rd),
    .rs1   (rs1),
    .rs2   (rs2),
    .imm   (imm),
    .word  (w_word),
    .legal (w_legal)
  );

  assign w_idle    = (r_state == ST_IDLE);
  assign in_ready  = w_idle && !base_load;
  assign w_accept  = in_valid && in_ready;
  assign w_wr_done = (r_state == ST_WR_HI);
  assign {w_ptr_carry, w_ptr_next} = {1'b0, r_wr_ptr} + 17'd2;

  // NOTE: sequential state uses non-blocking assignments and an async reset in the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && w_legal) w_next_state = ST_WR_LO;
      ST_WR_LO: w_next_state = ST_WR_HI;
      ST_WR_HI: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Memory port is a pure function of state so reset silences it immediately.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      ST_WR_LO: if (r_legal) begin
        mem_we    = 1'b1;
        mem_addr  = r_wr_ptr;
        mem_wdata = r_word[7:0];
      end
      ST_WR_HI: if (r_legal) begin
        mem_we    = 1'b1;
        mem_addr  = r_wr_ptr + 16'd1;
        mem_wdata = r_word[15:8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word      <= '0;
      r_legal     <= 1'b0;
      r_wr_ptr    <= '0;
      r_instr_cnt <= '0;
      r_wrap      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_word  <= w_word;
        r_legal <= w_legal;
      end
      if (w_idle && base_load) begin
        r_wr_ptr <= base_addr;
        r_wrap   <= 1'b0;
      end else if (w_wr_done) begin
        r_wr_ptr    <= w_ptr_next;
        r_instr_cnt <= r_instr_cnt + 16'd1;
        if (w_ptr_carry) r_wrap <= 1'b1;
      end
    end
  end

  // A new rejection outranks err_clr; err_op follows it if err was clear or being cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err    <= 1'b0;
      r_err_op <= '0;
    end else if (w_accept && !w_legal) begin
      r_err <= 1'b1;
      if (!r_err || err_clr) r_err_op <= op;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign instr_cnt = r_instr_cnt;
  assign err       = r_err;
  assign err_op    = r_err_op;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of encodings plus hand-written
// sequences for error flags, pointer wrap, base_load timing and mid-write reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        base_load;
  logic [15:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [2:0]  rd, rs1, rs2;
  logic [15:0] imm;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [15:0] instr_cnt;
  logic        err;
  logic [3:0]  err_op;
  logic        err_clr;
  logic        wrap;

  instr_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .base_load (base_load),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .instr_cnt (instr_cnt),
    .err       (err),
    .err_op    (err_op),
    .err_clr   (err_clr),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    logic [15:0] word;
    bit          legal;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         wq[$];
  vec_t        vecs[20];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_ptr;
  logic [15:0] exp_cnt;

  // Byte writes are captured on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) wq.push_back('{mem_addr, mem_wdata});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Drive one instruction at a falling edge and follow it for three cycles.
  task automatic issue(input vec_t v, input bit bl_mid, input bit clr_with, input logic [3:0] exp_eop);
    wq.delete();
    op = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    in_valid = 1'b1;
    err_clr  = clr_with;
    #1 check({v.name, " in_ready_pre"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    err_clr  = 1'b0;
    if (bl_mid) begin
      base_load = 1'b1;
      base_addr = 16'h5000;
    end
    #1 check({v.name, " in_ready_c1"}, in_ready, !v.legal);
    if (!v.legal) begin
      check({v.name, " err"}, err, 1);
      check({v.name, " err_op"}, err_op, exp_eop);
    end
    @(negedge clk);
    #1 check({v.name, " in_ready_c2"}, in_ready, !v.legal);
    @(negedge clk);
    base_load = 1'b0;
    #1 check({v.name, " in_ready_c3"}, in_ready, 1);
    if (v.legal) begin
      check({v.name, " nwrites"}, wq.size(), 2);
      if (wq.size() == 2) begin
        check({v.name, " lo_addr"}, wq[0].a, exp_ptr);
        check({v.name, " lo_data"}, wq[0].d, v.word[7:0]);
        check({v.name, " hi_addr"}, wq[1].a, exp_ptr + 16'd1);
        check({v.name, " hi_data"}, wq[1].d, v.word[15:8]);
      end
      exp_ptr = exp_ptr + 16'd2;
      exp_cnt = exp_cnt + 16'd1;
    end else begin
      check({v.name, " nwrites"}, wq.size(), 0);
    end
    check({v.name, " instr_cnt"}, instr_cnt, exp_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ptr = 16'h0000;
    exp_cnt = 16'h0000;
  endtask

  initial begin
    vec_t hv;

    vecs[0]  = '{"add",     4'h8, 3'd1, 3'd2, 3'd3, 16'h0000, 16'h8298, 1'b1};
    vecs[1]  = '{"addi32",  4'hC, 3'd1, 3'd0, 3'd0, 16'h0020, 16'h0000, 1'b0};
    vecs[2]  = '{"lui",     4'hE, 3'd7, 3'd0, 3'd0, 16'h00AB, 16'hEEAB, 1'b1};
    vecs[3]  = '{"jal_m1",  4'h0, 3'd0, 3'd0, 3'd0, 16'hFFFF, 16'h01FF, 1'b1};
    vecs[4]  = '{"sub",     4'h9, 3'd7, 3'd7, 3'd7, 16'h0000, 16'h9FF8, 1'b1};
    vecs[5]  = '{"lw_m32",  4'h5, 3'd2, 3'd3, 3'd0, 16'hFFE0, 16'h54E0, 1'b1};
    vecs[6]  = '{"sw_31",   4'h7, 3'd0, 3'd1, 3'd5, 16'h001F, 16'h7A5F, 1'b1};
    vecs[7]  = '{"ble_m33", 4'h3, 3'd0, 3'd4, 3'd6, 16'hFFDF, 16'h0000, 1'b0};
    vecs[8]  = '{"jal_255", 4'h0, 3'd3, 3'd0, 3'd0, 16'h00FF, 16'h06FF, 1'b1};
    vecs[9]  = '{"jal_m256",4'h0, 3'd0, 3'd0, 3'd0, 16'hFF00, 16'h0100, 1'b1};
    vecs[10] = '{"jal_256", 4'h0, 3'd0, 3'd0, 3'd0, 16'h0100, 16'h0000, 1'b0};
    vecs[11] = '{"lui_256", 4'hE, 3'd1, 3'd0, 3'd0, 16'h0100, 16'h0000, 1'b0};
    vecs[12] = '{"op_ill",  4'hF, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0};
    vecs[13] = '{"and",     4'hA, 3'd0, 3'd1, 3'd2, 16'h0000, 16'hA050, 1'b1};
    vecs[14] = '{"jalr",    4'h1, 3'd1, 3'd2, 3'd0, 16'h0004, 16'h1284, 1'b1};
    vecs[15] = '{"sb_m1",   4'h6, 3'd0, 3'd4, 3'd3, 16'hFFFF, 16'h673F, 1'b1};
    vecs[16] = '{"beq",     4'h2, 3'd0, 3'd7, 3'd0, 16'h001F, 16'h2E1F, 1'b1};
    vecs[17] = '{"subi",    4'hD, 3'd2, 3'd5, 3'd0, 16'hFFE1, 16'hD561, 1'b1};
    vecs[18] = '{"or",      4'hB, 3'd5, 3'd6, 3'd1, 16'h0000, 16'hBB88, 1'b1};
    vecs[19] = '{"lb",      4'h4, 3'd6, 3'd7, 3'd0, 16'h0010, 16'h4DD0, 1'b1};

    rst = 1'b1; base_load = 1'b0; base_addr = '0; in_valid = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0; err_clr = 1'b0;
    exp_ptr = '0; exp_cnt = '0;

    // Reset values while reset is held.
    @(negedge clk);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst instr_cnt", instr_cnt, 0);
    check("rst err", err, 0);
    check("rst err_op", err_op, 0);
    check("rst wrap", wrap, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst in_ready", in_ready, 1);

    // Encoding table, from base 0x0000.
    for (int i = 0; i < 20; i++) begin
      pulse_err_clr();
      issue(vecs[i], 1'b0, 1'b0, vecs[i].op);
      if (!vecs[i].legal) begin
        pulse_err_clr();
        check({vecs[i].name, " err_cleared"}, err, 0);
      end
    end

    // Sticky error: err_op holds the first op until cleared; clear+illegal keeps err.
    pulse_err_clr();
    issue(vecs[12], 1'b0, 1'b0, 4'hF);
    issue(vecs[11], 1'b0, 1'b0, 4'hF);
    issue(vecs[7],  1'b0, 1'b1, 4'h3);
    check("clr_ill err", err, 1);
    pulse_err_clr();
    check("clr err", err, 0);
    check("clr err_op_kept", err_op, 4'h3);

    // base_load together with in_valid: pointer loads, instruction waits a cycle.
    hv = '{"beq_wrap", 4'h2, 3'd0, 3'd1, 3'd2, 16'hFFFE, 16'h22BE, 1'b1};
    wq.delete();
    op = hv.op; rd = hv.rd; rs1 = hv.rs1; rs2 = hv.rs2; imm = hv.imm;
    in_valid = 1'b1; base_load = 1'b1; base_addr = 16'hFFFE;
    #1 check("bl in_ready", in_ready, 0);
    @(negedge clk);
    base_load = 1'b0;
    #1 check("bl not_accepted", in_ready, 1);
    check("bl no_write", mem_we, 0);
    exp_ptr = 16'hFFFE;
    issue(hv, 1'b0, 1'b0, 4'h0);
    check("wrap set", wrap, 1);
    issue(vecs[0], 1'b0, 1'b0, 4'h0);
    check("wrap sticky", wrap, 1);

    // base_load in IDLE clears wrap; base_load while writing is ignored.
    base_load = 1'b1; base_addr = 16'h0100;
    @(negedge clk);
    base_load = 1'b0;
    check("bl wrap_clr", wrap, 0);
    exp_ptr = 16'h0100;
    issue(vecs[2], 1'b1, 1'b0, 4'h0);
    issue(vecs[4], 1'b0, 1'b0, 4'h0);

    // Reset during WR_HI: only the low byte reaches memory.
    do_reset();
    wq.delete();
    op = vecs[0].op; rd = vecs[0].rd; rs1 = vecs[0].rs1; rs2 = vecs[0].rs2; imm = vecs[0].imm;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("abort mem_we", mem_we, 0);
    check("abort mem_addr", mem_addr, 0);
    check("abort instr_cnt", instr_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 check("abort nwrites", wq.size(), 1);
    if (wq.size() >= 1) begin
      check("abort lo_addr", wq[0].a, 16'h0000);
      check("abort lo_data", wq[0].d, 8'h98);
    end
    check("abort in_ready", in_ready, 1);
    check("abort cnt_after", instr_cnt, 0);
    issue(vecs[3], 1'b0, 1'b0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
